// File: rtl/cve2_pkg.sv
// Shared types for the cve2 memory-port arbiter (see CVE2_MEM_ARB_RR_EN in the top).
package cve2_pkg;

    localparam int unsigned BusAw = 32;
    localparam int unsigned BusDw = 32;
    localparam int unsigned BusBw = 4;

    typedef enum logic {ARB_SRC_INSTR = 1'b0, ARB_SRC_DATA = 1'b1} arb_src_e;

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

    typedef struct packed {
        logic             we;
        logic [BusBw-1:0] be;
        logic [BusAw-1:0] addr;
        logic [BusDw-1:0] wdata;
    } bus_payload_t;

endpackage

// File: rtl/cve2_arb_src_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered bus transactions.
module cve2_arb_src_fifo
    import cve2_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  arb_src_e wdata,
    output arb_src_e head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    arb_src_e        mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign head    = mem[rptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= next_ptr(wptr);
            if (do_pop)  rptr <= next_ptr(rptr);
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // ID storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/cve2_mem_port_arbiter.sv
// Shares one OBI memory port between instruction fetch and LSU, routing responses in issue order.
// Optional macro CVE2_MEM_ARB_RR_EN: round-robin arbitration (default: data has fixed priority).
module cve2_mem_port_arbiter
    import cve2_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_req_i,
    input  logic [BusAw-1:0] instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [BusBw-1:0] data_be_i,
    input  logic [BusAw-1:0] data_addr_i,
    input  logic [BusDw-1:0] data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [BusDw-1:0] rdata_o,
    output logic             err_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [BusBw-1:0] bus_be_o,
    output logic [BusAw-1:0] bus_addr_o,
    output logic [BusDw-1:0] bus_wdata_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    input  logic [BusDw-1:0] bus_rdata_i,
    input  logic             bus_err_i,
    output logic             busy_o,
    output logic             unexp_rvalid_o
);

    arb_state_e   state;
    arb_state_e   state_nxt;
    arb_src_e     pick;
    arb_src_e     sel;
    arb_src_e     sel_q;
    arb_src_e     last_q;
    arb_src_e     head;
    bus_payload_t live;
    bus_payload_t held_q;
    bus_payload_t pay;
    logic         fifo_full;
    logic         fifo_empty;
    logic         full;
    logic         rvalid;
    logic         bus_req;
    logic         gnt;
    logic         unexp_q;

    // Source choice for a fresh arbitration round.
    always_comb begin
        pick = ARB_SRC_INSTR;
`ifdef CVE2_MEM_ARB_RR_EN
        if (instr_req_i && data_req_i) begin
            pick = (last_q == ARB_SRC_DATA) ? ARB_SRC_INSTR : ARB_SRC_DATA;
        end else if (data_req_i) begin
            pick = ARB_SRC_DATA;
        end
`else
        if (data_req_i) pick = ARB_SRC_DATA;
`endif
    end

    // Payload of the picked source; fetches are always full-word reads.
    always_comb begin
        live = '{we: 1'b0, be: 4'hF, addr: instr_addr_i, wdata: '0};
        if (pick == ARB_SRC_DATA) begin
            live = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
        end
    end

    // A response in the same cycle frees a slot, so a full FIFO may still accept a grant.
    assign full    = fifo_full & ~bus_rvalid_i;
    assign rvalid  = bus_rvalid_i & ~rst_i;
    assign bus_req = (instr_req_i | data_req_i) & ~full & ~rst_i;
    assign gnt     = bus_gnt_i & bus_req;

    // Next state and selection: while holding, selection and payload stay frozen.
    always_comb begin
        state_nxt = state;
        sel       = pick;
        pay       = live;
        unique case (state)
            ARB_IDLE: begin
                if (bus_req && !bus_gnt_i) state_nxt = ARB_HOLD;
            end
            ARB_HOLD: begin
                sel = sel_q;
                pay = held_q;
                if (gnt) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // FSM state, frozen selection/payload and round-robin history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ARB_IDLE;
            sel_q  <= ARB_SRC_INSTR;
            held_q <= '0;
            last_q <= ARB_SRC_DATA;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE) begin
                sel_q  <= pick;
                held_q <= live;
            end
            if (gnt) last_q <= sel;
        end
    end

    // Sticky flag for responses that arrive with nothing outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            unexp_q <= 1'b0;
        end else if (bus_rvalid_i && fifo_empty) begin
            unexp_q <= 1'b1;
        end
    end

    cve2_arb_src_fifo #(
        .Depth (MaxOutstanding)
    ) u_src_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (gnt),
        .pop   (rvalid),
        .wdata (sel),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus_req_o      = bus_req;
    assign bus_we_o       = rst_i ? 1'b0 : pay.we;
    assign bus_be_o       = rst_i ? '0 : pay.be;
    assign bus_addr_o     = rst_i ? '0 : pay.addr;
    assign bus_wdata_o    = rst_i ? '0 : pay.wdata;
    assign instr_gnt_o    = gnt & (sel == ARB_SRC_INSTR);
    assign data_gnt_o     = gnt & (sel == ARB_SRC_DATA);
    assign instr_rvalid_o = rvalid & ~fifo_empty & (head == ARB_SRC_INSTR);
    assign data_rvalid_o  = rvalid & ~fifo_empty & (head == ARB_SRC_DATA);
    assign rdata_o        = rst_i ? '0 : bus_rdata_i;
    assign err_o          = bus_err_i & ~rst_i;
    assign busy_o         = (~fifo_empty | bus_req) & ~rst_i;
    assign unexp_rvalid_o = unexp_q;

endmodule
